// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES decrypt-datapath definitions: byte/word/state typedefs, the
// GF(2^8) reduction constant, constant multipliers used by InvMixColumns and
// a single-column InvMixColumns helper.
// Byte order everywhere: byte 0 is the most significant byte; a 32-bit word
// holds rows 0..3 of one column, row 0 in [31:24].
// ---------------------------------------------------------------------------
package aes_pkg;

   localparam int NCOL = 4;

   typedef logic [7:0]   byte_t;
   typedef logic [31:0]  word_t;
   typedef logic [127:0] state_t;

   // x^8 + x^4 + x^3 + x + 1 with the x^8 term dropped
   localparam byte_t GF_POLY = 8'h1B;

   function automatic byte_t xtime(input byte_t a);
      return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
   endfunction

   function automatic byte_t gf_mul9(input byte_t a);
      byte_t x2, x4, x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ a;
   endfunction

   function automatic byte_t gf_mul11(input byte_t a);
      byte_t x2, x4, x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x2 ^ a;
   endfunction

   function automatic byte_t gf_mul13(input byte_t a);
      byte_t x2, x4, x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ a;
   endfunction

   function automatic byte_t gf_mul14(input byte_t a);
      byte_t x2, x4, x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction

   // out_r = 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3), indices mod 4
   function automatic word_t inv_mix_column(input word_t w);
      byte_t a0, a1, a2, a3;
      a0 = w[31:24];
      a1 = w[23:16];
      a2 = w[15:8];
      a3 = w[7:0];
      return {gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
              gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3) ^ gf_mul9(a0),
              gf_mul14(a2) ^ gf_mul11(a3) ^ gf_mul13(a0) ^ gf_mul9(a1),
              gf_mul14(a3) ^ gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)};
   endfunction

endpackage

// File: rtl/inv_sbox.sv
// ---------------------------------------------------------------------------
// inv_sbox
// AES inverse S-box as a 256-entry case table with a registered output
// (one cycle latency). Pure datapath: no reset.
// Ports:
//   clk  rising-edge clock
//   a    byte to substitute
//   q    InvSubBytes(a), valid one cycle after a
// ---------------------------------------------------------------------------
module inv_sbox
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic [7:0] a,
   output logic [7:0] q
);

   byte_t lut;

   always_comb begin
      lut = 8'h00;
      case (a)
         8'h00: lut = 8'h52; 8'h01: lut = 8'h09; 8'h02: lut = 8'h6a; 8'h03: lut = 8'hd5; 8'h04: lut = 8'h30; 8'h05: lut = 8'h36; 8'h06: lut = 8'ha5; 8'h07: lut = 8'h38;
         8'h08: lut = 8'hbf; 8'h09: lut = 8'h40; 8'h0a: lut = 8'ha3; 8'h0b: lut = 8'h9e; 8'h0c: lut = 8'h81; 8'h0d: lut = 8'hf3; 8'h0e: lut = 8'hd7; 8'h0f: lut = 8'hfb;
         8'h10: lut = 8'h7c; 8'h11: lut = 8'he3; 8'h12: lut = 8'h39; 8'h13: lut = 8'h82; 8'h14: lut = 8'h9b; 8'h15: lut = 8'h2f; 8'h16: lut = 8'hff; 8'h17: lut = 8'h87;
         8'h18: lut = 8'h34; 8'h19: lut = 8'h8e; 8'h1a: lut = 8'h43; 8'h1b: lut = 8'h44; 8'h1c: lut = 8'hc4; 8'h1d: lut = 8'hde; 8'h1e: lut = 8'he9; 8'h1f: lut = 8'hcb;
         8'h20: lut = 8'h54; 8'h21: lut = 8'h7b; 8'h22: lut = 8'h94; 8'h23: lut = 8'h32; 8'h24: lut = 8'ha6; 8'h25: lut = 8'hc2; 8'h26: lut = 8'h23; 8'h27: lut = 8'h3d;
         8'h28: lut = 8'hee; 8'h29: lut = 8'h4c; 8'h2a: lut = 8'h95; 8'h2b: lut = 8'h0b; 8'h2c: lut = 8'h42; 8'h2d: lut = 8'hfa; 8'h2e: lut = 8'hc3; 8'h2f: lut = 8'h4e;
         8'h30: lut = 8'h08; 8'h31: lut = 8'h2e; 8'h32: lut = 8'ha1; 8'h33: lut = 8'h66; 8'h34: lut = 8'h28; 8'h35: lut = 8'hd9; 8'h36: lut = 8'h24; 8'h37: lut = 8'hb2;
         8'h38: lut = 8'h76; 8'h39: lut = 8'h5b; 8'h3a: lut = 8'ha2; 8'h3b: lut = 8'h49; 8'h3c: lut = 8'h6d; 8'h3d: lut = 8'h8b; 8'h3e: lut = 8'hd1; 8'h3f: lut = 8'h25;
         8'h40: lut = 8'h72; 8'h41: lut = 8'hf8; 8'h42: lut = 8'hf6; 8'h43: lut = 8'h64; 8'h44: lut = 8'h86; 8'h45: lut = 8'h68; 8'h46: lut = 8'h98; 8'h47: lut = 8'h16;
         8'h48: lut = 8'hd4; 8'h49: lut = 8'ha4; 8'h4a: lut = 8'h5c; 8'h4b: lut = 8'hcc; 8'h4c: lut = 8'h5d; 8'h4d: lut = 8'h65; 8'h4e: lut = 8'hb6; 8'h4f: lut = 8'h92;
         8'h50: lut = 8'h6c; 8'h51: lut = 8'h70; 8'h52: lut = 8'h48; 8'h53: lut = 8'h50; 8'h54: lut = 8'hfd; 8'h55: lut = 8'hed; 8'h56: lut = 8'hb9; 8'h57: lut = 8'hda;
         8'h58: lut = 8'h5e; 8'h59: lut = 8'h15; 8'h5a: lut = 8'h46; 8'h5b: lut = 8'h57; 8'h5c: lut = 8'ha7; 8'h5d: lut = 8'h8d; 8'h5e: lut = 8'h9d; 8'h5f: lut = 8'h84;
         8'h60: lut = 8'h90; 8'h61: lut = 8'hd8; 8'h62: lut = 8'hab; 8'h63: lut = 8'h00; 8'h64: lut = 8'h8c; 8'h65: lut = 8'hbc; 8'h66: lut = 8'hd3; 8'h67: lut = 8'h0a;
         8'h68: lut = 8'hf7; 8'h69: lut = 8'he4; 8'h6a: lut = 8'h58; 8'h6b: lut = 8'h05; 8'h6c: lut = 8'hb8; 8'h6d: lut = 8'hb3; 8'h6e: lut = 8'h45; 8'h6f: lut = 8'h06;
         8'h70: lut = 8'hd0; 8'h71: lut = 8'h2c; 8'h72: lut = 8'h1e; 8'h73: lut = 8'h8f; 8'h74: lut = 8'hca; 8'h75: lut = 8'h3f; 8'h76: lut = 8'h0f; 8'h77: lut = 8'h02;
         8'h78: lut = 8'hc1; 8'h79: lut = 8'haf; 8'h7a: lut = 8'hbd; 8'h7b: lut = 8'h03; 8'h7c: lut = 8'h01; 8'h7d: lut = 8'h13; 8'h7e: lut = 8'h8a; 8'h7f: lut = 8'h6b;
         8'h80: lut = 8'h3a; 8'h81: lut = 8'h91; 8'h82: lut = 8'h11; 8'h83: lut = 8'h41; 8'h84: lut = 8'h4f; 8'h85: lut = 8'h67; 8'h86: lut = 8'hdc; 8'h87: lut = 8'hea;
         8'h88: lut = 8'h97; 8'h89: lut = 8'hf2; 8'h8a: lut = 8'hcf; 8'h8b: lut = 8'hce; 8'h8c: lut = 8'hf0; 8'h8d: lut = 8'hb4; 8'h8e: lut = 8'he6; 8'h8f: lut = 8'h73;
         8'h90: lut = 8'h96; 8'h91: lut = 8'hac; 8'h92: lut = 8'h74; 8'h93: lut = 8'h22; 8'h94: lut = 8'he7; 8'h95: lut = 8'had; 8'h96: lut = 8'h35; 8'h97: lut = 8'h85;
         8'h98: lut = 8'he2; 8'h99: lut = 8'hf9; 8'h9a: lut = 8'h37; 8'h9b: lut = 8'he8; 8'h9c: lut = 8'h1c; 8'h9d: lut = 8'h75; 8'h9e: lut = 8'hdf; 8'h9f: lut = 8'h6e;
         8'ha0: lut = 8'h47; 8'ha1: lut = 8'hf1; 8'ha2: lut = 8'h1a; 8'ha3: lut = 8'h71; 8'ha4: lut = 8'h1d; 8'ha5: lut = 8'h29; 8'ha6: lut = 8'hc5; 8'ha7: lut = 8'h89;
         8'ha8: lut = 8'h6f; 8'ha9: lut = 8'hb7; 8'haa: lut = 8'h62; 8'hab: lut = 8'h0e; 8'hac: lut = 8'haa; 8'had: lut = 8'h18; 8'hae: lut = 8'hbe; 8'haf: lut = 8'h1b;
         8'hb0: lut = 8'hfc; 8'hb1: lut = 8'h56; 8'hb2: lut = 8'h3e; 8'hb3: lut = 8'h4b; 8'hb4: lut = 8'hc6; 8'hb5: lut = 8'hd2; 8'hb6: lut = 8'h79; 8'hb7: lut = 8'h20;
         8'hb8: lut = 8'h9a; 8'hb9: lut = 8'hdb; 8'hba: lut = 8'hc0; 8'hbb: lut = 8'hfe; 8'hbc: lut = 8'h78; 8'hbd: lut = 8'hcd; 8'hbe: lut = 8'h5a; 8'hbf: lut = 8'hf4;
         8'hc0: lut = 8'h1f; 8'hc1: lut = 8'hdd; 8'hc2: lut = 8'ha8; 8'hc3: lut = 8'h33; 8'hc4: lut = 8'h88; 8'hc5: lut = 8'h07; 8'hc6: lut = 8'hc7; 8'hc7: lut = 8'h31;
         8'hc8: lut = 8'hb1; 8'hc9: lut = 8'h12; 8'hca: lut = 8'h10; 8'hcb: lut = 8'h59; 8'hcc: lut = 8'h27; 8'hcd: lut = 8'h80; 8'hce: lut = 8'hec; 8'hcf: lut = 8'h5f;
         8'hd0: lut = 8'h60; 8'hd1: lut = 8'h51; 8'hd2: lut = 8'h7f; 8'hd3: lut = 8'ha9; 8'hd4: lut = 8'h19; 8'hd5: lut = 8'hb5; 8'hd6: lut = 8'h4a; 8'hd7: lut = 8'h0d;
         8'hd8: lut = 8'h2d; 8'hd9: lut = 8'he5; 8'hda: lut = 8'h7a; 8'hdb: lut = 8'h9f; 8'hdc: lut = 8'h93; 8'hdd: lut = 8'hc9; 8'hde: lut = 8'h9c; 8'hdf: lut = 8'hef;
         8'he0: lut = 8'ha0; 8'he1: lut = 8'he0; 8'he2: lut = 8'h3b; 8'he3: lut = 8'h4d; 8'he4: lut = 8'hae; 8'he5: lut = 8'h2a; 8'he6: lut = 8'hf5; 8'he7: lut = 8'hb0;
         8'he8: lut = 8'hc8; 8'he9: lut = 8'heb; 8'hea: lut = 8'hbb; 8'heb: lut = 8'h3c; 8'hec: lut = 8'h83; 8'hed: lut = 8'h53; 8'hee: lut = 8'h99; 8'hef: lut = 8'h61;
         8'hf0: lut = 8'h17; 8'hf1: lut = 8'h2b; 8'hf2: lut = 8'h04; 8'hf3: lut = 8'h7e; 8'hf4: lut = 8'hba; 8'hf5: lut = 8'h77; 8'hf6: lut = 8'hd6; 8'hf7: lut = 8'h26;
         8'hf8: lut = 8'he1; 8'hf9: lut = 8'h69; 8'hfa: lut = 8'h14; 8'hfb: lut = 8'h63; 8'hfc: lut = 8'h55; 8'hfd: lut = 8'h21; 8'hfe: lut = 8'h0c; 8'hff: lut = 8'h7d;
         default: lut = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      q <= lut;
   end

endmodule

// File: rtl/aes_inv_round_seq.sv
// ---------------------------------------------------------------------------
// aes_inv_round_seq
// Iterative single-round AES decryption (equivalent inverse cipher order):
// InvShiftRows + InvSubBytes on one column per cycle through four registered
// inverse S-boxes, then InvMixColumns (skipped on the last round) and the
// round-key XOR. Accept at cycle T -> out_valid at T+6; 7 cycles per round.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input handshake; in_ready high only when idle
//   in_state, in_key     128-bit state and round key, byte 0 = [127:120]
//   in_last              final round: InvMixColumns skipped
//   out_valid/out_ready  output handshake; result held until accepted
//   out_state            128-bit round result
// Build option: define AES_DEC_KEY_MIX_EN to pass the key column through
// InvMixColumns on non-last rounds (accepts untransformed schedule keys).
// ---------------------------------------------------------------------------
module aes_inv_round_seq #(
   parameter int NCOL = aes_pkg::NCOL
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic [127:0] in_key,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state
);
   import aes_pkg::*;

   localparam int CW = $clog2(NCOL);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic [1:0]    fsm_q;
   logic [CW-1:0] col_q;
   state_t        st_q;
   state_t        key_q;
   logic          last_q;
   logic          vld_p1;
   logic [CW-1:0] col_p1;
   state_t        out_q;

   byte_t sb_in [4];
   byte_t sb_q  [4];
   word_t sub_w, mix_w, key_w, keyx_w, res_w;

   assign in_ready  = (fsm_q == S_IDLE);
   assign out_valid = (fsm_q == S_HOLD);
   assign out_state = out_q;

   // ---- stage p0: InvShiftRows gather, row r from column (col - r) mod 4
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         sb_in[r] = 8'h00;
         for (int c = 0; c < NCOL; c++) begin
            if ((col_q - CW'(r)) == CW'(c)) sb_in[r] = st_q[127-8*(4*c+r) -: 8];
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      inv_sbox u_sbox (
         .clk (clk),
         .a   (sb_in[g]),
         .q   (sb_q[g])
      );
   end

   // ---- stage p1: InvMixColumns + key XOR on the column substituted last cycle
   always_comb begin
      sub_w = {sb_q[0], sb_q[1], sb_q[2], sb_q[3]};
      mix_w = last_q ? sub_w : inv_mix_column(sub_w);
      key_w = 32'h0;
      for (int c = 0; c < NCOL; c++) begin
         if (col_p1 == CW'(c)) key_w = key_q[127-32*c -: 32];
      end
`ifdef AES_DEC_KEY_MIX_EN
      keyx_w = last_q ? key_w : inv_mix_column(key_w);
`else
      keyx_w = key_w;
`endif
      res_w = mix_w ^ keyx_w;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q  <= S_IDLE;
         col_q  <= '0;
         st_q   <= '0;
         key_q  <= '0;
         last_q <= 1'b0;
         vld_p1 <= 1'b0;
         col_p1 <= '0;
         out_q  <= '0;
      end else begin
         // a column issued this cycle is finished next cycle
         vld_p1 <= (fsm_q == S_ISSUE);
         col_p1 <= col_q;
         for (int c = 0; c < NCOL; c++) begin
            if (vld_p1 && (col_p1 == CW'(c))) out_q[127-32*c -: 32] <= res_w;
         end
         case (fsm_q)
            S_IDLE: begin
               if (in_valid) begin
                  st_q   <= in_state;
                  key_q  <= in_key;
                  last_q <= in_last;
                  col_q  <= '0;
                  fsm_q  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (col_q == CW'(NCOL-1)) begin
                  col_q <= '0;
                  fsm_q <= S_DRAIN;
               end else begin
                  col_q <= col_q + CW'(1);
               end
            end
            S_DRAIN: fsm_q <= S_HOLD;
            default: begin
               if (out_ready) fsm_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_inv_round_seq.sv
module tb_aes_inv_round_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic [127:0] in_key;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   aes_inv_round_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .in_key    (in_key),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state)
   );

   typedef struct {
      string        name;
      logic [127:0] st;
      logic [127:0] key;
      logic         last;
      logic [127:0] exp;
   } vec_t;

   localparam int NV = 8;
   vec_t vec [NV];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Offer one round; returns at the negedge of cycle T+1.
   task automatic offer(input logic [127:0] st, input logic [127:0] key, input logic last);
      int w;
      w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("ready_before_accept", 128'(in_ready), 128'(1));
      in_valid = 1'b1;
      in_state = st;
      in_key   = key;
      in_last  = last;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int start, output int lat);
      lat = start;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic pop(input string name);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({name, "_valid_drop"}, 128'(out_valid), 128'(0));
      chk({name, "_ready_back"}, 128'(in_ready), 128'(1));
   endtask

   task automatic full_round(input int i);
      int lat;
      offer(vec[i].st, vec[i].key, vec[i].last);
      wait_valid(1, lat);
      chk({vec[i].name, "_latency"}, 128'(lat), 128'(6));
      chk({vec[i].name, "_data"}, out_state, vec[i].exp);
      pop(vec[i].name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      vec[0] = '{"c1_last", 128'h7ad5fda789ef4e272bca100b3d9ff59f,
                 128'h549932d1f08557681093ed9cbe2c974e, 1'b1,
                 128'he9f74eec023020f61bf2ccf2353c21c7};
      vec[1] = '{"zero_last", 128'h0, 128'h0, 1'b1, {16{8'h52}}};
      vec[2] = '{"zero_mid", 128'h0, 128'h0, 1'b0, {16{8'h52}}};
      vec[3] = '{"key01_mid", 128'h0, {16{8'h01}}, 1'b0, {16{8'h53}}};
      // 7c -> 01 and 63 -> 00 through the inverse S-box
      vec[4] = '{"shift_last", 128'h63636363_63636363_63636363_637c6363, 128'h0, 1'b1,
                 128'h00010000_00000000_00000000_00000000};
      vec[5] = '{"shift_mix_mid", 128'h63636363_63636363_63636363_637c6363,
                 128'h01010101_02020202_03030303_04040404, 1'b0,
                 128'h0a0f080c_02020202_03030303_04040404};
      vec[6] = '{"mix_row0_mid", 128'h7c636363_63636363_63636363_63636363, 128'h0, 1'b0,
                 128'h0e090d0b_00000000_00000000_00000000};
`ifdef AES_DEC_KEY_MIX_EN
      vec[7] = '{"keycol_mid", 128'h0, 128'h01000000_00000000_00000000_00000000, 1'b0,
                 128'h5c5b5f59_52525252_52525252_52525252};
`else
      vec[7] = '{"keycol_mid", 128'h0, 128'h01000000_00000000_00000000_00000000, 1'b0,
                 128'h53525252_52525252_52525252_52525252};
`endif

      rst = 1'b1; in_valid = 1'b0; in_state = '0; in_key = '0; in_last = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_in_ready", 128'(in_ready), 128'(1));
      chk("reset_out_valid", 128'(out_valid), 128'(0));
      chk("reset_out_state", out_state, 128'h0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < NV; i++) full_round(i);

      // backpressure: result held 20 cycles with consumer stalled
      offer(vec[0].st, vec[0].key, vec[0].last);
      wait_valid(1, lat);
      chk("bp_latency", 128'(lat), 128'(6));
      for (int k = 0; k < 20; k++) begin
         chk("bp_hold", {out_state, in_ready, out_valid}, {vec[0].exp, 1'b0, 1'b1});
         @(negedge clk);
      end
      chk("bp_final", out_state, vec[0].exp);
      pop("bp");

      // new data offered during ISSUE must be ignored
      offer(vec[4].st, vec[4].key, vec[4].last);
      in_valid = 1'b1;
      in_state = vec[0].st;
      in_key   = 128'hffffffff_ffffffff_ffffffff_ffffffff;
      in_last  = 1'b0;
      for (int k = 0; k < 3; k++) @(negedge clk);
      in_valid = 1'b0;
      wait_valid(4, lat);
      chk("ign_latency", 128'(lat), 128'(6));
      chk("ign_data", out_state, vec[4].exp);
      pop("ign");

      // reset with column 2 in the issue slot
      offer(vec[0].st, vec[0].key, vec[0].last);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_out_valid", 128'(out_valid), 128'(0));
      chk("rst_mid_out_state", out_state, 128'h0);
      chk("rst_mid_in_ready", 128'(in_ready), 128'(1));
      rst = 1'b0;
      @(negedge clk);
      full_round(5);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
